mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit unified memory (1000 words) between the CPU instruction-fetch port and the LD/STR data port.
- Accepts at most one request per grant opportunity and drives the memory's address, data_in and write_en pins from registers.
- Captures the memory's combinational read data and returns it with a valid pulse.
- Sits between the CPU datapath and the memory block.

Parameters:
- DEPTH, 1000, number of implemented memory words; addresses >= DEPTH are out of range.
- STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win (fixed-priority mode only); valid range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request; held with i_addr until i_gnt.
- i_addr  input  16  fetch word address.
- i_gnt  output  1  fetch accepted this cycle (combinational).
- i_rvalid  output  1  one-cycle pulse; i_rdata valid.
- i_rdata  output  16  fetched word.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  16  data word address.
- d_wdata  input  16  store data.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_rvalid  output  1  one-cycle pulse; load data valid, or store acknowledged.
- d_rdata  output  16  loaded word.
- addr_err  output  1  one-cycle pulse alongside rvalid when the access was out of range.
- mem_address  output  16  to memory address.
- mem_data_in  output  16  to memory data_in.
- mem_write_en  output  1  to memory write_en.
- mem_data_out  input  16  from memory data_out (combinational read).

Behaviour:
- Reset: all registered outputs are 0: rvalids, rdatas, addr_err, mem_address, mem_data_in, mem_write_en. State is IDLE and the starve counter is 0. Reset is asynchronous: asserted mid-ACCESS, it drops mem_write_en immediately, the pending write is lost, and no rvalid is produced.
- Two-state FSM, IDLE and ACCESS. Grants are issued only in IDLE; i_gnt and d_gnt are never asserted together.
- IDLE with any request:
  - Assert the winner's gnt.
  - At the clock edge, latch the winner's address into mem_address, the winner's wdata into mem_data_in, and we into mem_write_en.
  - Record the winner's identity; move to ACCESS.
  - mem_write_en = we AND (addr < DEPTH).
- ACCESS:
  - The memory write commits at the end of this cycle.
  - At the edge, capture mem_data_out into the winner's rdata for an in-range load. An out-of-range load captures 16'h0000; a store leaves rdata unchanged.
  - Pulse the winner's rvalid in the next cycle; addr_err pulses with it if the access was out of range.
  - Clear mem_write_en; return to IDLE.
- Latency: gnt in cycle N, memory access in N+1, rvalid/rdata in N+2. A new grant is possible in cycle N+2, giving one access per 2 cycles at peak.
- Fixed priority (default):
  - d_req wins over i_req.
  - The starve counter increments each IDLE cycle in which i_req is denied, and resets to 0 whenever fetch is granted or i_req is low.
  - When the counter reaches STARVE_LIMIT, fetch wins the next IDLE cycle even if d_req is high.
- Non-winning requesters see no gnt and must keep their request held.
- No request in IDLE: outputs hold and mem_write_en stays 0.
- Address compare is unsigned 16-bit; 16'hFFFF is out of range.
- Read data from a same-address store granted in the previous transaction reflects the stored value, because the write commits before the next ACCESS.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- When defined: the starve counter is removed; a last-winner bit selects the port that did not win most recently when both request; the last-winner bit resets to "fetch won", so data wins the first tie.
- When undefined: fixed priority with STARVE_LIMIT behaviour as above.

Test Plan:
- Reset, then i_req, i_addr=16'h0100, memory holding {MOV,2,0}=16'h8200 -> i_gnt in cycle 0, mem_address=16'h0100 in cycle 1, i_rvalid with i_rdata=16'h8200 in cycle 2, d_rvalid=0.
- d_req, d_we=1, d_addr=2, d_wdata=16'h0012, then load of address 2 -> mem_write_en high exactly one cycle; load returns 16'h0012; d_rvalid pulses twice.
- i_req and d_req held continuously, fixed priority, STARVE_LIMIT=4 -> grants in order D,D,D,D,I,D,D,D,D,I; under MEM_ARB_ROUND_ROBIN_EN the order is D,I,D,I.
- d_we=1, d_addr=16'd1000 -> mem_write_en stays 0; d_rvalid and addr_err pulse together; a later read of address 999 is unchanged. A load of 16'hFFFF returns 16'h0000 with addr_err.
- Store granted, rst_n asserted during ACCESS -> mem_write_en falls asynchronously, the target word is unmodified, no rvalid, state IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory pins around mem_port_arbiter.
// slave = arbiter side, master = CPU/memory side.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        addr_err;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_en;
    logic [15:0] mem_data_out;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err,
               mem_address, mem_data_in, mem_write_en
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err,
               mem_address, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-port unified memory; one access per 2 cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties instead of data-first with starvation guard.
module mem_port_arbiter #(
    parameter int unsigned DEPTH        = 1000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state, state_nxt;
    logic        any_req, pick_d;
    logic [15:0] sel_addr;
    logic        sel_in_range, acc_in_range;
    logic        win_d, acc_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]  starve_cnt;
    logic        starved;
`endif

    always_comb begin
        state_nxt = state;
        bus.i_gnt = 1'b0;
        bus.d_gnt = 1'b0;
        any_req   = bus.i_req | bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d    = bus.d_req && (!bus.i_req || !last_d);
`else
        starved   = (starve_cnt >= LIMIT);
        pick_d    = bus.d_req && !(bus.i_req && starved);
`endif
        sel_addr     = pick_d ? bus.d_addr : bus.i_addr;
        sel_in_range = (sel_addr < DEPTH_W);
        acc_in_range = (bus.mem_address < DEPTH_W);
        case (state)
            IDLE: begin
                if (any_req) begin
                    bus.d_gnt = pick_d;
                    bus.i_gnt = !pick_d;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_rvalid     <= 1'b0;
            bus.i_rdata      <= '0;
            bus.d_rvalid     <= 1'b0;
            bus.d_rdata      <= '0;
            bus.addr_err     <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_data_in  <= '0;
            bus.mem_write_en <= 1'b0;
            win_d            <= 1'b0;
            acc_we           <= 1'b0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.mem_address  <= sel_addr;
                        bus.mem_data_in  <= pick_d ? bus.d_wdata : 16'h0000;
                        // Out-of-range stores never reach the memory pins.
                        bus.mem_write_en <= pick_d & bus.d_we & sel_in_range;
                        win_d            <= pick_d;
                        acc_we           <= pick_d & bus.d_we;
                    end
                end
                ACCESS: begin
                    bus.mem_write_en <= 1'b0;
                    bus.addr_err     <= !acc_in_range;
                    if (win_d) begin
                        bus.d_rvalid <= 1'b1;
                        if (!acc_we)
                            bus.d_rdata <= acc_in_range ? bus.mem_data_out : 16'h0000;
                    end else begin
                        bus.i_rvalid <= 1'b1;
                        bus.i_rdata  <= acc_in_range ? bus.mem_data_out : 16'h0000;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Reset value 0 means "fetch won last", so data takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     last_d <= 1'b0;
        else if (state == IDLE && any_req) last_d <= pick_d;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          starve_cnt <= '0;
        else if (!bus.i_req || bus.i_gnt)    starve_cnt <= '0;
        else if (state == IDLE && starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1000-word memory.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.DEPTH(1000), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    logic        pre = 1'b0;

    always @(posedge clk) begin
        if (!pre) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 16'h0000;
            mem[16'h0100] <= 16'h8200;
            mem[999]      <= 16'h1234;
            mem[7]        <= 16'h7777;
            pre <= 1'b1;
        end else if (bus.mem_write_en && bus.mem_address < 16'd1000) begin
            mem[bus.mem_address[9:0]] <= bus.mem_data_in;
        end
    end

    assign bus.mem_data_out = (bus.mem_address < 16'd1000) ? mem[bus.mem_address[9:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [9:0] seq;
    logic [9:0] seq_exp;
    int         ng;

    initial begin
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        #3;
        chk("rst_mem_we",   32'(bus.mem_write_en), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_address),  32'h0);
        chk("rst_mem_din",  32'(bus.mem_data_in),  32'h0);
        chk("rst_rvalids",  32'({bus.i_rvalid, bus.d_rvalid, bus.addr_err}), 32'h0);
        chk("rst_rdatas",   32'({bus.i_rdata, bus.d_rdata}), 32'h0);
        #5 rst_n = 1'b1;

        // Instruction fetch of 0x0100
        cyc();
        bus.i_req = 1'b1; bus.i_addr = 16'h0100;
        #1 chk("f_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'h2);
        cyc();
        bus.i_req = 1'b0;
        #1 chk("f_mem_addr", 32'(bus.mem_address), 32'h0100);
        chk("f_mem_we", 32'(bus.mem_write_en), 32'h0);
        chk("f_early_rv", 32'(bus.i_rvalid), 32'h0);
        cyc();
        #1 chk("f_rvalid", 32'({bus.i_rvalid, bus.d_rvalid, bus.addr_err}), 32'h4);
        chk("f_rdata", 32'(bus.i_rdata), 32'h8200);
        cyc();
        #1 chk("f_rv_pulse", 32'(bus.i_rvalid), 32'h0);

        // Store 0x0012 to 2, then load it back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd2; bus.d_wdata = 16'h0012;
        #1 chk("st_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'h1);
        cyc();
        bus.d_req = 1'b0;
        #1 chk("st_gnt_lo", 32'({bus.i_gnt, bus.d_gnt}), 32'h0);
        chk("st_we_hi",  32'(bus.mem_write_en), 32'h1);
        chk("st_addr",   32'(bus.mem_address),  32'd2);
        chk("st_din",    32'(bus.mem_data_in),  32'h0012);
        cyc();
        #1 chk("st_we_lo", 32'(bus.mem_write_en), 32'h0);
        chk("st_rvalid", 32'({bus.d_rvalid, bus.addr_err}), 32'h2);
        chk("st_mem2",   32'(mem[2]), 32'h0012);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd2;
        #1 chk("ld_gnt", 32'(bus.d_gnt), 32'h1);
        cyc();
        bus.d_req = 1'b0;
        #1 chk("ld_we", 32'(bus.mem_write_en), 32'h0);
        cyc();
        #1 chk("ld_rvalid", 32'({bus.d_rvalid, bus.addr_err}), 32'h2);
        chk("ld_rdata", 32'(bus.d_rdata), 32'h0012);

        // Both ports held: arbitration order over 10 grants
        cyc();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'd6;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd5;
        seq = '0; ng = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("gnt_excl", 32'(bus.i_gnt & bus.d_gnt), 32'h0);
            if (bus.i_gnt || bus.d_gnt) begin
                if (ng < 10) seq[ng] = bus.d_gnt;
                ng++;
            end
            if (k == 19) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            cyc();
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        seq_exp = 10'b0101010101;
`else
        seq_exp = 10'b0111101111;
`endif
        chk("arb_ngrants", 32'(ng), 32'd10);
        chk("arb_order",   32'(seq), 32'(seq_exp));

        // Out-of-range store to 1000
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd1000; bus.d_wdata = 16'hBEEF;
        #1 chk("oor_st_gnt", 32'(bus.d_gnt), 32'h1);
        cyc();
        bus.d_req = 1'b0;
        #1 chk("oor_st_we", 32'(bus.mem_write_en), 32'h0);
        cyc();
        #1 chk("oor_st_err", 32'({bus.d_rvalid, bus.addr_err}), 32'h3);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd999;
        cyc();
        bus.d_req = 1'b0;
        cyc();
        #1 chk("ld999_rv", 32'({bus.d_rvalid, bus.addr_err}), 32'h2);
        chk("ld999_data", 32'(bus.d_rdata), 32'h1234);
        bus.d_req = 1'b1; bus.d_addr = 16'hFFFF;
        cyc();
        bus.d_req = 1'b0;
        cyc();
        #1 chk("ldffff_rv", 32'({bus.d_rvalid, bus.addr_err}), 32'h3);
        chk("ldffff_data", 32'(bus.d_rdata), 32'h0000);

        // Reset asserted during a store's ACCESS cycle
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd7; bus.d_wdata = 16'h5555;
        #1 chk("rs_gnt", 32'(bus.d_gnt), 32'h1);
        cyc();
        bus.d_req = 1'b0;
        #1 chk("rs_we_hi", 32'(bus.mem_write_en), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("rs_we_async", 32'(bus.mem_write_en), 32'h0);
        cyc();
        rst_n = 1'b1;
        #1 chk("rs_mem7", 32'(mem[7]), 32'h7777);
        chk("rs_no_rv", 32'({bus.i_rvalid, bus.d_rvalid}), 32'h0);
        cyc();
        #1 chk("rs_no_rv2", 32'({bus.i_rvalid, bus.d_rvalid}), 32'h0);
        bus.i_req = 1'b1; bus.i_addr = 16'd7;
        #1 chk("rs_idle_gnt", 32'(bus.i_gnt), 32'h1);
        cyc();
        bus.i_req = 1'b0;
        cyc();
        #1 chk("rs_fetch7", 32'({bus.i_rvalid, bus.i_rdata}), {15'h0, 1'b1, 16'h7777});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
